// File: rtl/div_restoring.sv
// div_restoring: iterative unsigned restoring divider, one quotient bit per clock.
// Start/done handshake; divide-by-zero returns all-ones quotient and the dividend as remainder.
module div_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DZERO, FIN} state_t;
  state_t           r_state, w_next;
  logic [WIDTH:0]   r_rem, w_t, w_rem;
  logic [WIDTH-1:0] r_q, r_d, w_q;
  logic [CW-1:0]    r_cnt;
  logic             w_ge, w_unused;
  // The partial remainder stays below the divisor, so its MSB is never consumed.
  assign w_unused = r_rem[WIDTH];
  assign w_t      = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge     = w_t >= {1'b0, r_d};
  assign w_rem    = w_ge ? w_t - {1'b0, r_d} : w_t;
  assign w_q      = {r_q[WIDTH-2:0], w_ge};
  always_comb begin
    w_next = r_state == IDLE  ? (start ? (divisor == '0 ? DZERO : CALC) : IDLE) :
             r_state == CALC  ? (r_cnt == CW'(WIDTH - 1) ? FIN : CALC) :
             r_state == DZERO ? FIN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= w_next == CALC;
      done    <= w_next == FIN;
      if (r_state == IDLE && start) begin
        r_rem <= '0;
        r_q   <= dividend;
        r_d   <= divisor;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_rem <= w_rem;
        r_q   <= w_q;
        r_cnt <= r_cnt + CW'(1);
      end
      // Results capture the final step directly on the FIN entry edge.
      if (r_state == CALC && w_next == FIN) begin
        quotient    <= w_q;
        remainder   <= w_rem[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end else if (r_state == DZERO) begin
        quotient    <= '1;
        remainder   <= r_q;
        div_by_zero <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring: randomized/directed scoreboard bench for div_restoring (WIDTH=4).
module tb_div_restoring;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {int a; int b; int q; int r; bit z;} exp_t;
  exp_t sb[$];
  exp_t last;
  int checks = 0, errs = 0;

  div_restoring #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.z = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 0;
    end
    return e;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), int'(e.z));
          if (!e.z) begin
            chk("identity", int'(quotient) * e.b + int'(remainder), e.a);
            chk("rem_lt_div", int'(int'(remainder) < e.b), 1);
          end
        end
      end
    end
  endtask

  task automatic do_op(input int a, input int b, input bit abuse = 0);
    int lat = 0, bcnt = 0;
    bit seen = 0;
    exp_t e;
    e = model(a, b);
    @(negedge clk);
    start = 1;
    dividend = W'(a);
    divisor = W'(b);
    sb.push_back(e);
    last = e;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1;
      start = (abuse && busy && !seen) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abuse) begin
        dividend = 9;
        divisor = 2;
      end
    end
    start = 0;
    chk("latency", seen ? lat : -1, b == 0 ? 2 : W + 1);
    chk("busy_cycles", bcnt, b == 0 ? 0 : W);
  endtask

  initial begin
    int n, ndone, prev;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy, done, quotient, remainder, div_by_zero}), 0);
    rst_n = 1;
    do_op(13, 3);
    do_op(15, 1);
    do_op(3, 9);
    do_op(0, 5);
    do_op(15, 15);
    repeat (10) begin
      @(negedge clk);
      chk("hold_quotient", int'(quotient), last.q);
      chk("hold_remainder", int'(remainder), last.r);
    end
    do_op(7, 0);
    do_op(8, 2);
    @(negedge clk);
    start = 1;
    dividend = 14;
    divisor = 4;
    repeat (3) sb.push_back(model(14, 4));
    n = 0;
    ndone = 0;
    prev = -1;
    while (ndone < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (prev >= 0) chk("done_spacing", n - prev, W + 2);
        prev = n;
        ndone++;
      end
    end
    start = 0;
    chk("held_dones", ndone, 3);
    do_op(14, 4, 1);
    @(negedge clk);
    start = 1;
    dividend = 11;
    divisor = 2;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("midreset_outputs", int'({busy, done, quotient, remainder, div_by_zero}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      chk("no_done_after_reset", int'(done), 0);
    end
    do_op(11, 2);
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) do_op(a, b);
    repeat (40) begin
      int ra, rb;
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
